// File: rtl/mux_scan_pkg.sv
// Shared mode encodings and helpers for the mux_scan_sel channel selector.
// Optional channel masking is enabled by defining MUX_SCAN_MASK_EN.
package mux_scan_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    function automatic int next_chan(input int cur, input int n);
        return (cur == n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell counter for auto-scan: ticks on the last cycle of each dwell.
// Optional channel masking is enabled by defining MUX_SCAN_MASK_EN.
module scan_dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_eff;

    // clr makes this cycle count as zero, so a fresh dwell is full length
    assign cnt_eff = clr ? '0 : cnt_q;
    assign tick    = en && (cnt_eff == LAST);

    always_comb begin
        cnt_d = cnt_eff;
        if (en) begin
            cnt_d = tick ? '0 : cnt_eff + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// N-way W-bit registered channel selector: manual, auto-scan and hold modes.
// Define MUX_SCAN_MASK_EN to add the ch_mask channel-enable input.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       data_in,
    input  logic [$clog2(N)-1:0] sel,
    input  logic [1:0]           mode,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]         ch_mask,
`endif
    output logic [W-1:0]         data_out,
    output logic [$clog2(N)-1:0] cur_sel,
    output logic                 sel_chg
);

    localparam int SW = $clog2(N);
    localparam int NP = 1 << SW;

    logic [SW-1:0] cur_q, cur_d;
    logic [W-1:0]  data_q, data_d;
    logic          chg_q;
    logic          auto_q;
    logic          cnt_en, cnt_clr, tick;
    logic [SW-1:0] adv;
    logic [NP-1:0] mask_pad;

    // Zero padding makes out-of-range indices read as disabled
`ifdef MUX_SCAN_MASK_EN
    assign mask_pad = NP'(ch_mask);
`else
    assign mask_pad = NP'({N{1'b1}});
`endif

    function automatic logic [W-1:0] chan(
        input logic [N*W-1:0] d,
        input logic [SW-1:0]  idx
    );
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(idx) == k) r = d[k*W +: W];
        end
        return r;
    endfunction

`ifdef MUX_SCAN_MASK_EN
    function automatic logic [SW-1:0] next_en(
        input logic [SW-1:0] cur,
        input logic [NP-1:0] m
    );
        logic [SW-1:0] r;
        int idx;
        r = cur;
        // Walk offsets high to low so the nearest enabled channel wins
        for (int i = N; i >= 1; i--) begin
            idx = int'(cur) + i;
            if (idx >= N) idx = idx - N;
            if (m[idx]) r = SW'(idx);
        end
        return r;
    endfunction

    assign adv = next_en(cur_q, mask_pad);
`else
    assign adv = SW'(next_chan(int'(cur_q), N));
`endif

    scan_dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .tick(tick)
    );

    always_comb begin
        cur_d   = cur_q;
        data_d  = data_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        unique case (mode)
            MODE_AUTO: begin
                cnt_en  = 1'b1;
                cnt_clr = !auto_q;
                if (tick) cur_d = adv;
                data_d = mask_pad[cur_d] ? chan(data_in, cur_d) : '0;
            end
            MODE_HOLD: begin
            end
            default: begin
                cnt_clr = 1'b1;
                if (mask_pad[sel]) begin
                    cur_d  = sel;
                    data_d = chan(data_in, sel);
                end else begin
                    data_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q  <= '0;
            data_q <= '0;
            chg_q  <= 1'b0;
            auto_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            data_q <= data_d;
            chg_q  <= (cur_d != cur_q);
            auto_q <= (mode == MODE_AUTO);
        end
    end

    assign data_out = data_q;
    assign cur_sel  = cur_q;
    assign sel_chg  = chg_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed self-checking bench for mux_scan_sel (two configurations).
// Mask tests are included when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data0;
    logic [1:0] sel0, mode0;
    logic [1:0] dout0, cur0;
    logic       chg0;
    logic [5:0] data1;
    logic [1:0] sel1, mode1;
    logic [1:0] dout1, cur1;
    logic       chg1;
`ifdef MUX_SCAN_MASK_EN
    logic [3:0] mask0;
    logic [2:0] mask1;
`endif

    int checks = 0;
    int failures = 0;
    int exp_cur [10] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    int prev;

    always #5 clk = ~clk;

    mux_scan_sel #(.N(4), .W(2), .DWELL(3)) u0 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data0),
        .sel     (sel0),
        .mode    (mode0),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask (mask0),
`endif
        .data_out(dout0),
        .cur_sel (cur0),
        .sel_chg (chg0)
    );

    mux_scan_sel #(.N(3), .W(2), .DWELL(1)) u1 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data1),
        .sel     (sel1),
        .mode    (mode1),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask (mask1),
`endif
        .data_out(dout1),
        .cur_sel (cur1),
        .sel_chg (chg1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk0(input string tag, input int c, input int d, input int g);
        chk({tag, ".cur"}, int'(cur0), c);
        chk({tag, ".dout"}, int'(dout0), d);
        chk({tag, ".chg"}, int'(chg0), g);
    endtask

    task automatic chk1(input string tag, input int c, input int d, input int g);
        chk({tag, ".cur"}, int'(cur1), c);
        chk({tag, ".dout"}, int'(dout1), d);
        chk({tag, ".chg"}, int'(chg1), g);
    endtask

    initial begin
        rst   = 1'b1;
        data0 = 8'b11_10_01_00;
        sel0  = 2'd0;
        mode0 = 2'b00;
        data1 = 6'd0;
        sel1  = 2'd0;
        mode1 = 2'b00;
`ifdef MUX_SCAN_MASK_EN
        mask0 = 4'b1111;
        mask1 = 3'b111;
`endif
        step();
        step();
        chk0("reset", 0, 0, 0);
        rst  = 1'b0;
        sel0 = 2'd2;
        chk("man_latency", int'(dout0), 0);
        step();
        chk0("man_sel2", 2, 2, 1);
        step();
        chk0("man_hold_sel", 2, 2, 0);
        data0 = 8'b00_01_11_10;
        step();
        chk0("man_live", 2, 1, 0);
        data0 = 8'b11_10_01_00;

        mode0 = 2'b01;
        step();
        chk0("auto_e1_pre", 2, 2, 0);
        prev = 2;
        for (int i = 2; i < 10; i++) begin
            step();
            chk0($sformatf("auto_%0d", i), exp_cur[i], exp_cur[i],
                 (exp_cur[i] != prev) ? 1 : 0);
            prev = exp_cur[i];
        end
        data0 = 8'b11_10_00_00;
        step();
        chk0("auto_live", 1, 0, 0);

        mode0 = 2'b10;
        data0 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk0($sformatf("hold_%0d", i), 1, 0, 0);
        end
        data0 = 8'b11_10_01_00;
        mode0 = 2'b01;
        step();
        chk0("reauto_1", 1, 1, 0);
        step();
        chk0("reauto_2", 1, 1, 0);
        step();
        chk0("reauto_3", 2, 2, 1);

        mode0 = 2'b00;
        sel0  = 2'd0;
        step();
        chk0("auto_to_man", 0, 0, 1);
        step();
        chk0("man_same", 0, 0, 0);
        mode0 = 2'b11;
        sel0  = 2'd3;
        step();
        chk0("reserved", 3, 3, 1);

        mode0 = 2'b01;
        step();
        step();
        chk0("pre_rst", 3, 3, 0);
        #2 rst = 1'b1;
        #1 chk0("async_rst", 0, 0, 0);
        chk1("async_rst_u1", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk0("post_rst_1", 0, 0, 0);
        step();
        chk0("post_rst_2", 0, 0, 0);
        step();
        chk0("post_rst_3", 1, 1, 1);

        data1 = 6'b10_01_11;
        mode1 = 2'b01;
        step();
        chk1("n3_1", 1, 1, 1);
        step();
        chk1("n3_2", 2, 2, 1);
        step();
        chk1("n3_wrap", 0, 3, 1);
        step();
        chk1("n3_4", 1, 1, 1);
        mode1 = 2'b00;
        sel1  = 2'd3;
        step();
        chk1("n3_oor", 1, 0, 0);
        sel1 = 2'd2;
        step();
        chk1("n3_man2", 2, 2, 1);

`ifdef MUX_SCAN_MASK_EN
        mode0 = 2'b00;
        sel0  = 2'd1;
        step();
        chk0("msk_man1", 1, 1, 1);
        mask0 = 4'b1010;
        sel0  = 2'd0;
        step();
        chk0("msk_man_masked", 1, 0, 0);
        mode0 = 2'b01;
        step();
        step();
        step();
        chk0("msk_auto_3", 3, 3, 1);
        step();
        step();
        step();
        chk0("msk_auto_1", 1, 1, 1);
        step();
        step();
        step();
        chk0("msk_auto_3b", 3, 3, 1);
        mask0 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk0($sformatf("msk_none_%0d", i), 3, 0, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
